// File: rtl/base_bus_sched_pkg.sv
// Shared constants, state encoding and helpers for the base-RAM / UART bus scheduler.
package base_bus_sched_pkg;

    localparam logic [31:0] UART_DATA_ADDR_DEF = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR_DEF = 32'hBFD0_03FC;
    localparam logic [31:0] SRAM_BASE_DEF      = 32'h8000_0000;
    localparam int          SRAM_ADDR_W_DEF    = 20;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_S_RD   = 4'd1,
        ST_S_WR1  = 4'd2,
        ST_S_WR2  = 4'd3,
        ST_U_RDW  = 4'd4,
        ST_U_RD1  = 4'd5,
        ST_U_RD2  = 4'd6,
        ST_U_WR1  = 4'd7,
        ST_U_WR2  = 4'd8,
        ST_U_TBRE = 4'd9,
        ST_U_TSRE = 4'd10,
        ST_STAT   = 4'd11
    } bus_state_e;

    typedef enum logic [1:0] {
        TGT_SRAM      = 2'd0,
        TGT_UART_DATA = 2'd1,
        TGT_UART_STAT = 2'd2,
        TGT_NONE      = 2'd3
    } bus_tgt_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } bus_gnt_e;

    // The UART is byte-wide: pick the lowest enabled lane of the store data.
    function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [3:0] be);
        logic [7:0] b;
        if (be[0]) begin
            b = data[7:0];
        end else if (be[1]) begin
            b = data[15:8];
        end else if (be[2]) begin
            b = data[23:16];
        end else if (be[3]) begin
            b = data[31:24];
        end else begin
            b = data[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/base_bus_sched_addr_decode.sv
// Combinational address decoder: 32-bit byte address to bus target.
module base_bus_sched_addr_decode
    import base_bus_sched_pkg::*;
#(
    parameter logic [31:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
    parameter logic [31:0] SRAM_BASE      = SRAM_BASE_DEF,
    parameter int          SRAM_ADDR_W    = SRAM_ADDR_W_DEF
) (
    input  logic [31:0] addr_i,
    output bus_tgt_e    tgt_o
);

    // UART registers are exact matches; SRAM is a power-of-two window above SRAM_BASE.
    always_comb begin
        if (addr_i == UART_DATA_ADDR) begin
            tgt_o = TGT_UART_DATA;
        end else if (addr_i == UART_STAT_ADDR) begin
            tgt_o = TGT_UART_STAT;
        end else if (addr_i[31:SRAM_ADDR_W+2] == SRAM_BASE[31:SRAM_ADDR_W+2]) begin
            tgt_o = TGT_SRAM;
        end else begin
            tgt_o = TGT_NONE;
        end
    end

endmodule

// File: rtl/base_bus_sched.sv
// Arbitrates the shared base-SRAM / UART bus between the fetch and memory ports
// and sequences the pin strobes for each access.
module base_bus_sched
    import base_bus_sched_pkg::*;
#(
    parameter logic [31:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
    parameter logic [31:0] SRAM_BASE      = SRAM_BASE_DEF,
    parameter int          SRAM_ADDR_W    = SRAM_ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic [31:0]            if_rdata,
    output logic                   if_done,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [31:0]            mem_addr,
    input  logic [3:0]             mem_be,
    input  logic [31:0]            mem_wdata,
    output logic [31:0]            mem_rdata,
    output logic                   mem_done,
    output logic                   stall_o,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [3:0]             sram_be_n,
    output logic                   uart_rdn,
    output logic                   uart_wrn,
    input  logic                   uart_tbre,
    input  logic                   uart_tsre,
    input  logic                   uart_data_ready,
    inout  wire  [31:0]            bus_data
);

    bus_state_e             state_q, state_d;
    bus_gnt_e               gnt_q, gnt_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic                   if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic [31:0]            if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic                   sram_ce_n_q, sram_ce_n_d, sram_oe_n_q, sram_oe_n_d;
    logic                   sram_we_n_q, sram_we_n_d;
    logic [3:0]             sram_be_n_q, sram_be_n_d;
    logic                   uart_rdn_q, uart_rdn_d, uart_wrn_q, uart_wrn_d;
    logic                   bus_oe_q, bus_oe_d;
    logic [31:0]            bus_out_q, bus_out_d;

    logic [31:0]            req_addr_s;
    logic                   req_we_s;
    logic                   req_take_s;
    bus_tgt_e               req_tgt_s;
    logic                   fin_s;
    logic [31:0]            fin_data_s;

    assign req_addr_s = mem_req ? mem_addr : if_addr;
    assign req_we_s   = mem_req & mem_we;
    // A request held high during its own done cycle belongs to the finished access.
    assign req_take_s = (state_q == ST_IDLE) & ~if_done_q & ~mem_done_q & (if_req | mem_req);

    base_bus_sched_addr_decode #(
        .UART_DATA_ADDR (UART_DATA_ADDR),
        .UART_STAT_ADDR (UART_STAT_ADDR),
        .SRAM_BASE      (SRAM_BASE),
        .SRAM_ADDR_W    (SRAM_ADDR_W)
    ) u_decode (
        .addr_i (req_addr_s),
        .tgt_o  (req_tgt_s)
    );

    // Next-state, request latching and completion data.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        sram_addr_d = sram_addr_q;
        fin_s       = 1'b0;
        fin_data_s  = 32'h0000_0000;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_take_s) begin
                    gnt_d       = mem_req ? GNT_MEM : GNT_IF;
                    be_d        = mem_req ? mem_be : 4'hF;
                    wdata_d     = mem_req ? mem_wdata : 32'h0000_0000;
                    sram_addr_d = req_addr_s[SRAM_ADDR_W+1:2];
                    case (req_tgt_s)
                        TGT_SRAM:      state_d = req_we_s ? ST_S_WR1 : ST_S_RD;
                        TGT_UART_DATA: state_d = req_we_s ? ST_U_WR1 : ST_U_RDW;
                        TGT_UART_STAT: begin
                            if (req_we_s) begin
                                fin_s = 1'b1;
                            end else begin
                                state_d = ST_STAT;
                            end
                        end
                        default:       fin_s = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S_RD: begin
                fin_s      = 1'b1;
                fin_data_s = bus_data;
            end
            ST_S_WR1:  state_d = ST_S_WR2;
            ST_S_WR2:  fin_s = 1'b1;
            ST_U_RDW: begin
                if (uart_data_ready) begin
                    state_d = ST_U_RD1;
                end else begin
                    state_d = ST_U_RDW;
                end
            end
            ST_U_RD1:  state_d = ST_U_RD2;
            ST_U_RD2: begin
                fin_s      = 1'b1;
                fin_data_s = {24'h00_0000, bus_data[7:0]};
            end
            ST_U_WR1:  state_d = ST_U_WR2;
            ST_U_WR2:  state_d = ST_U_TBRE;
            ST_U_TBRE: begin
                if (uart_tbre) begin
                    state_d = ST_U_TSRE;
                end else begin
                    state_d = ST_U_TBRE;
                end
            end
            ST_U_TSRE: begin
                if (uart_tsre) begin
                    fin_s = 1'b1;
                end else begin
                    state_d = ST_U_TSRE;
                end
            end
            ST_STAT: begin
                fin_s      = 1'b1;
                fin_data_s = {30'h0000_0000, uart_data_ready, uart_tbre & uart_tsre};
            end
            default:   state_d = ST_IDLE;
        endcase

        if (fin_s) begin
            state_d = ST_IDLE;
            if (gnt_d == GNT_MEM) begin
                mem_done_d  = 1'b1;
                mem_rdata_d = fin_data_s;
            end else begin
                if_done_d  = 1'b1;
                if_rdata_d = fin_data_s;
            end
        end else begin
            fin_data_s = 32'h0000_0000;
        end
    end

    // Pin values are derived from the next state so strobes line up with the state register.
    always_comb begin
        sram_ce_n_d = 1'b1;
        sram_oe_n_d = 1'b1;
        sram_we_n_d = 1'b1;
        sram_be_n_d = 4'hF;
        uart_rdn_d  = 1'b1;
        uart_wrn_d  = 1'b1;
        bus_oe_d    = 1'b0;
        bus_out_d   = bus_out_q;
        case (state_d)
            ST_S_RD: begin
                sram_ce_n_d = 1'b0;
                sram_oe_n_d = 1'b0;
                sram_be_n_d = ~be_d;
            end
            ST_S_WR1, ST_S_WR2: begin
                sram_ce_n_d = 1'b0;
                sram_we_n_d = (state_d == ST_S_WR1) ? 1'b0 : 1'b1;
                sram_be_n_d = ~be_d;
                bus_oe_d    = 1'b1;
                bus_out_d   = wdata_d;
            end
            ST_U_RD1, ST_U_RD2: uart_rdn_d = 1'b0;
            ST_U_WR1, ST_U_WR2: begin
                uart_wrn_d = (state_d == ST_U_WR1) ? 1'b0 : 1'b1;
                bus_oe_d   = 1'b1;
                bus_out_d  = {24'h00_0000, lane_byte(wdata_d, be_d)};
            end
            default: bus_oe_d = 1'b0;
        endcase
    end

    // State, request latches and registered pin outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0000_0000;
            sram_addr_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
            sram_ce_n_q <= 1'b1;
            sram_oe_n_q <= 1'b1;
            sram_we_n_q <= 1'b1;
            sram_be_n_q <= 4'hF;
            uart_rdn_q  <= 1'b1;
            uart_wrn_q  <= 1'b1;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            sram_ce_n_q <= sram_ce_n_d;
            sram_oe_n_q <= sram_oe_n_d;
            sram_we_n_q <= sram_we_n_d;
            sram_be_n_q <= sram_be_n_d;
            uart_rdn_q  <= uart_rdn_d;
            uart_wrn_q  <= uart_wrn_d;
            bus_oe_q    <= bus_oe_d;
            bus_out_q   <= bus_out_d;
        end
    end

    assign stall_o   = (if_req & ~if_done_q) | (mem_req & ~mem_done_q);
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = sram_ce_n_q;
    assign sram_oe_n = sram_oe_n_q;
    assign sram_we_n = sram_we_n_q;
    assign sram_be_n = sram_be_n_q;
    assign uart_rdn  = uart_rdn_q;
    assign uart_wrn  = uart_wrn_q;
    assign bus_data  = bus_oe_q ? bus_out_q : {32{1'bz}};

endmodule

// File: tb/tb_base_bus_sched.sv
// Directed, table-driven bench for base_bus_sched with a simple SRAM/UART bus model.
module tb_base_bus_sched;

    logic        clk, rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_done, mem_done, stall_o;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;
    logic        uart_rdn, uart_wrn, uart_tbre, uart_tsre, uart_data_ready;
    wire  [31:0] bus_data;
    logic [31:0] tb_drv_val;
    logic        tb_drv_en;

    int n_chk  = 0;
    int n_pass = 0;

    base_bus_sched dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_o(stall_o), .sram_addr(sram_addr),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
        .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .uart_data_ready(uart_data_ready),
        .bus_data(bus_data)
    );

    // SRAM answers while ce/oe are low; UART answers while rdn is low.
    assign tb_drv_en = (~sram_ce_n & ~sram_oe_n) | ~uart_rdn;
    assign bus_data  = tb_drv_en ? tb_drv_val : {32{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;   // 1 = mem port, 0 = fetch port
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] drv;
        logic        rdy, tbre, tsre;
        int          lat;
        logic [31:0] rdata;
        int          oe, wen, rdn, wrn, ce;
        logic [31:0] wval;
        logic [31:0] saddr;
        logic [3:0]  ben;
    } vec_t;

    vec_t vecs[12];

    int          o_lat, o_oe, o_we, o_rdn, o_wrn, o_ce, o_stall_bad, o_inv_bad, o_pulse_bad;
    logic [31:0] o_rdata, o_wval, o_saddr;
    logic [3:0]  o_ben;

    function automatic vec_t mkv(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] drv,
                                 input logic rdy, input logic tbre, input logic tsre,
                                 input int lat, input logic [31:0] rdata,
                                 input int oe, input int wen, input int rdn, input int wrn, input int ce,
                                 input logic [31:0] wval, input logic [31:0] saddr, input logic [3:0] ben);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.drv = drv;
        v.rdy = rdy; v.tbre = tbre; v.tsre = tsre; v.lat = lat; v.rdata = rdata;
        v.oe = oe; v.wen = wen; v.rdn = rdn; v.wrn = wrn; v.ce = ce;
        v.wval = wval; v.saddr = saddr; v.ben = ben;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request, watch the pins every cycle until done (bounded), then release.
    task automatic do_txn(input vec_t v);
        int  cyc;
        bit  got;
        logic dn, other;
        o_oe = 0; o_we = 0; o_rdn = 0; o_wrn = 0; o_ce = 0;
        o_stall_bad = 0; o_inv_bad = 0; o_pulse_bad = 0;
        o_rdata = 32'h0; o_wval = 32'h0; o_saddr = 32'h0; o_ben = 4'hF;
        uart_data_ready = v.rdy; uart_tbre = v.tbre; uart_tsre = v.tsre;
        tb_drv_val = v.drv;
        if (v.port) begin
            mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_be = v.be; mem_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!sram_oe_n) o_oe++;
            if (!sram_we_n) begin o_we++; o_wval = bus_data; end
            if (!uart_rdn) o_rdn++;
            if (!uart_wrn) begin o_wrn++; o_wval = {24'h0, bus_data[7:0]}; end
            if (!sram_ce_n) begin o_ce++; o_saddr = {12'h0, sram_addr}; o_ben = sram_be_n; end
            if (!uart_rdn && !uart_wrn) o_inv_bad++;
            if (!sram_ce_n && (!uart_rdn || !uart_wrn)) o_inv_bad++;
            dn    = v.port ? mem_done : if_done;
            other = v.port ? if_done : mem_done;
            if (other) o_inv_bad++;
            if (dn) begin
                got = 1'b1;
                o_rdata = v.port ? mem_rdata : if_rdata;
                if (stall_o) o_stall_bad++;
            end else if (!stall_o) begin
                o_stall_bad++;
            end
        end
        o_lat = cyc;
        if_req = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        if (if_done || mem_done) o_pulse_bad++;
    endtask

    initial begin
        int          c_mem, c_if, c_wrn, c_rdn, c_rdn_first, c_bad;
        logic [31:0] c_val, c_val2;

        vecs[0]  = mkv(1'b0, 1'b0, 32'h8000_0010, 4'hF, 32'h0, 32'h3C08_BFD0, 1'b0, 1'b0, 1'b0,
                       2, 32'h3C08_BFD0, 1, 0, 0, 0, 1, 32'h0, 32'h0000_0004, 4'h0);
        vecs[1]  = mkv(1'b1, 1'b0, 32'h8000_0104, 4'hF, 32'h0, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0,
                       2, 32'hA5A5_1234, 1, 0, 0, 0, 1, 32'h0, 32'h0000_0041, 4'h0);
        vecs[2]  = mkv(1'b1, 1'b1, 32'h8000_0100, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0,
                       3, 32'h0, 0, 1, 0, 0, 2, 32'h1234_5678, 32'h0000_0040, 4'h0);
        vecs[3]  = mkv(1'b1, 1'b0, 32'hBFD0_03FC, 4'hF, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
                       2, 32'h0000_0002, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'hF);
        vecs[4]  = mkv(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0,
                       1, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'hF);
        vecs[5]  = mkv(1'b1, 1'b1, 32'hBFD0_03FC, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b1,
                       1, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'hF);
        vecs[6]  = mkv(1'b1, 1'b0, 32'hBFD0_03F8, 4'h1, 32'h0, 32'hABCD_EFFF, 1'b1, 1'b0, 1'b0,
                       4, 32'h0000_00FF, 0, 0, 2, 0, 0, 32'h0, 32'h0, 4'hF);
        vecs[7]  = mkv(1'b1, 1'b1, 32'hBFD0_03F8, 4'h2, 32'h0000_4100, 32'h0, 1'b0, 1'b1, 1'b1,
                       5, 32'h0, 0, 0, 0, 1, 0, 32'h0000_0041, 32'h0, 4'hF);
        vecs[8]  = mkv(1'b1, 1'b0, 32'hBFD0_03FC, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1,
                       2, 32'h0000_0001, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'hF);
        vecs[9]  = mkv(1'b0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 1'b0, 1'b0,
                       1, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'hF);
        vecs[10] = mkv(1'b1, 1'b1, 32'h8000_0008, 4'h4, 32'h00AB_0000, 32'h0, 1'b0, 1'b0, 1'b0,
                       3, 32'h0, 0, 1, 0, 0, 2, 32'h00AB_0000, 32'h0000_0002, 4'hB);
        vecs[11] = mkv(1'b0, 1'b0, 32'hBFD0_03FC, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1,
                       2, 32'h0000_0003, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'hF);

        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_be = 4'h0; mem_wdata = 32'h0;
        uart_tbre = 1'b0; uart_tsre = 1'b0; uart_data_ready = 1'b0; tb_drv_val = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset strobes", {31'h0, sram_ce_n & sram_oe_n & sram_we_n & uart_rdn & uart_wrn}, 32'h1);
        check("reset sram_be_n", {28'h0, sram_be_n}, 32'hF);
        check("reset done", {30'h0, if_done, mem_done}, 32'h0);
        check("reset stall", {31'h0, stall_o}, 32'h0);
        check("reset rdata", if_rdata | mem_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i]);
            check($sformatf("v%0d latency", i), o_lat, vecs[i].lat);
            if (!vecs[i].we) check($sformatf("v%0d rdata", i), o_rdata, vecs[i].rdata);
            check($sformatf("v%0d oe_n low cycles", i), o_oe, vecs[i].oe);
            check($sformatf("v%0d we_n low cycles", i), o_we, vecs[i].wen);
            check($sformatf("v%0d rdn low cycles", i), o_rdn, vecs[i].rdn);
            check($sformatf("v%0d wrn low cycles", i), o_wrn, vecs[i].wrn);
            check($sformatf("v%0d ce_n low cycles", i), o_ce, vecs[i].ce);
            if (vecs[i].we) check($sformatf("v%0d write data", i), o_wval, vecs[i].wval);
            if (vecs[i].ce > 0) begin
                check($sformatf("v%0d sram_addr", i), o_saddr, vecs[i].saddr);
                check($sformatf("v%0d sram_be_n", i), {28'h0, o_ben}, {28'h0, vecs[i].ben});
            end
            check($sformatf("v%0d stall", i), o_stall_bad, 32'h0);
            check($sformatf("v%0d invariants", i), o_inv_bad, 32'h0);
            check($sformatf("v%0d single pulse", i), o_pulse_bad, 32'h0);
        end

        // Simultaneous store and fetch: memory first, fetch granted after the done cycle.
        tb_drv_val = 32'h3C08_BFD0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0100; mem_be = 4'hF; mem_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h8000_0010;
        c_mem = 0; c_if = 0; c_bad = 0; c_wrn = 0; c_val = 32'h0; c_val2 = 32'h0;
        for (int k = 1; k <= 30 && c_if == 0; k++) begin
            @(negedge clk);
            if (!sram_we_n) c_wrn++;
            if (mem_done) begin c_mem = k; mem_req = 1'b0; end
            if (if_done) begin
                c_if = k; c_val = if_rdata; if_req = 1'b0;
                if (stall_o) c_bad++;
            end else if (!stall_o) begin
                c_bad++;
            end
            if (!sram_oe_n) c_val2 = {12'h0, sram_addr};
        end
        check("arb mem_done cycle", c_mem, 32'd3);
        check("arb if_done cycle", c_if, 32'd6);
        check("arb we_n low cycles", c_wrn, 32'd1);
        check("arb if_rdata", c_val, 32'h3C08_BFD0);
        check("arb fetch sram_addr", c_val2, 32'h0000_0004);
        check("arb stall", c_bad, 32'h0);
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);

        // UART store with late tbre (5 cycles) and tsre (3 more).
        uart_tbre = 1'b0; uart_tsre = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hBFD0_03F8; mem_be = 4'h1; mem_wdata = 32'h0000_0041;
        c_mem = 0; c_wrn = 0; c_bad = 0; c_val = 32'h0;
        for (int k = 1; k <= 30 && c_mem == 0; k++) begin
            @(negedge clk);
            if (!uart_wrn) begin c_wrn++; c_val = {24'h0, bus_data[7:0]}; end
            if (!sram_ce_n) c_bad++;
            if (mem_done) c_mem = k;
            uart_tbre = (k >= 5);
            uart_tsre = (k >= 8);
        end
        check("uwr mem_done cycle", c_mem, 32'd9);
        check("uwr wrn low cycles", c_wrn, 32'd1);
        check("uwr bus byte", c_val, 32'h0000_0041);
        check("uwr ce_n low", c_bad, 32'h0);
        mem_req = 1'b0;
        @(negedge clk);

        // UART load with data_ready late by 4 cycles.
        uart_data_ready = 1'b0; tb_drv_val = 32'h1234_56FF;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hBFD0_03F8; mem_be = 4'h1;
        c_mem = 0; c_rdn = 0; c_rdn_first = 0; c_val = 32'h0;
        for (int k = 1; k <= 30 && c_mem == 0; k++) begin
            @(negedge clk);
            if (!uart_rdn) begin
                c_rdn++;
                if (c_rdn_first == 0) c_rdn_first = k;
            end
            if (mem_done) begin c_mem = k; c_val = mem_rdata; end
            uart_data_ready = (k >= 4);
        end
        check("urd mem_done cycle", c_mem, 32'd7);
        check("urd first rdn cycle", c_rdn_first, 32'd5);
        check("urd rdn low cycles", c_rdn, 32'd2);
        check("urd mem_rdata", c_val, 32'h0000_00FF);
        mem_req = 1'b0; uart_data_ready = 1'b0;
        @(negedge clk);

        // Reset while waiting for tbre, then the held store runs again as a new access.
        uart_tbre = 1'b0; uart_tsre = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hBFD0_03F8; mem_be = 4'h1; mem_wdata = 32'h0000_005A;
        c_bad = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (mem_done) c_bad++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst abort no done", {31'h0, mem_done} | c_bad, 32'h0);
        check("rst abort wrn", {31'h0, uart_wrn}, 32'h1);
        check("rst abort ce_n", {31'h0, sram_ce_n}, 32'h1);
        check("rst abort mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
        c_mem = 0; c_wrn = 0; c_val = 32'h0;
        for (int k = 1; k <= 30 && c_mem == 0; k++) begin
            @(negedge clk);
            if (!uart_wrn) begin c_wrn++; c_val = {24'h0, bus_data[7:0]}; end
            if (mem_done) c_mem = k;
        end
        check("reissue mem_done cycle", c_mem, 32'd5);
        check("reissue wrn low cycles", c_wrn, 32'd1);
        check("reissue bus byte", c_val, 32'h0000_005A);
        mem_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
